// File: rtl/sdf_delay_line_if.sv
// Control, sample and status signals of one SDF delay line.
// The master drives samples and control; the slave (the delay line) returns the
// delayed tap and its fill status.
interface sdf_delay_line_if #(
    parameter int DATA_W    = 15,
    parameter int MAX_DEPTH = 16
);
    localparam int CW = $clog2(MAX_DEPTH) + 1;

    logic              en;
    logic              flush;
    logic [CW-1:0]     depth_cfg;
    logic [DATA_W-1:0] in_r;
    logic [DATA_W-1:0] in_i;
    logic              in_valid;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] out_i;
    logic              out_valid;
    logic [CW-1:0]     count;
    logic              primed;

    modport master (
        output en, flush, depth_cfg, in_r, in_i, in_valid,
        input  out_r, out_i, out_valid, count, primed
    );

    modport slave (
        input  en, flush, depth_cfg, in_r, in_i, in_valid,
        output out_r, out_i, out_valid, count, primed
    );
endinterface

// File: rtl/sdf_delay_line.sv
// Complex-sample delay line for the SDF FFT stages.
// MAX_DEPTH physical stages of {valid, re, im}; the output is tapped at stage
// d_act-1, so one instance provides any delay from 1 to MAX_DEPTH. The active
// depth is latched only at reset or flush so a stream never sees its delay move.
module sdf_delay_line #(
    parameter int DATA_W    = 15,
    parameter int MAX_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    sdf_delay_line_if.slave     bus
);
    localparam int CW    = $clog2(MAX_DEPTH) + 1;
    localparam int IDX_W = $clog2(MAX_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } stage_t;

    stage_t         stage_q [MAX_DEPTH];
    stage_t         stage_d [MAX_DEPTH];
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  d_act_q, d_act_d;
    logic [IDX_W-1:0] tap_idx;
    stage_t         tap;

    // Requested depth folded into 1..MAX_DEPTH.
    function automatic logic [CW-1:0] clamp_depth(input logic [CW-1:0] cfg);
        if (cfg == '0)
            return CW'(1);
        else if (cfg > CW'(MAX_DEPTH))
            return CW'(MAX_DEPTH);
        else
            return cfg;
    endfunction

    // d_act is always 1..MAX_DEPTH, so d_act-1 always fits the stage index.
    assign tap_idx = IDX_W'(d_act_q - CW'(1));
    assign tap     = stage_q[tap_idx];

    // Next state: flush clears and reloads depth, otherwise en shifts one stage.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        stage_d = stage_q;
        count_d = count_q;
        d_act_d = d_act_q;
        if (bus.flush) begin
            for (int k = 0; k < MAX_DEPTH; k++)
                stage_d[k] = '0;
            count_d = '0;
            d_act_d = clamp_depth(bus.depth_cfg);
        end else if (bus.en) begin
            for (int k = 1; k < MAX_DEPTH; k++)
                stage_d[k] = stage_q[k-1];
            stage_d[0] = '{valid: bus.in_valid, re: bus.in_r, im: bus.in_i};
            // Sample entering minus sample leaving the observed window.
            count_d = count_q + CW'(bus.in_valid) - CW'(tap.valid);
        end
    end

    // State registers with synchronous reset that behaves like a flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the storage array is reset on purpose: stale data with clear
            // valid bits would still be visible on out_r/out_i after reset.
            for (int k = 0; k < MAX_DEPTH; k++)
                stage_q[k] <= '0;
            count_q <= '0;
            d_act_q <= clamp_depth(bus.depth_cfg);
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
            d_act_q <= d_act_d;
        end
    end

    assign bus.out_r     = tap.re;
    assign bus.out_i     = tap.im;
    assign bus.out_valid = tap.valid;
    assign bus.count     = count_q;
    assign bus.primed    = (count_q == d_act_q);
endmodule

// File: tb/tb_sdf_delay_line.sv
// Directed bench for sdf_delay_line with MAX_DEPTH=16, DATA_W=15.
module tb_sdf_delay_line;
    localparam int DATA_W    = 15;
    localparam int MAX_DEPTH = 16;
    localparam int CW        = $clog2(MAX_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    sdf_delay_line_if #(.DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH)) bus ();

    sdf_delay_line #(.DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One rising edge, then settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int re, input int im);
        bus.in_valid = v;
        bus.in_r     = DATA_W'(re);
        bus.in_i     = DATA_W'(im);
    endtask

    task automatic apply_reset(input int cfg);
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.flush     = 1'b0;
        bus.depth_cfg = CW'(cfg);
        drive(1'b1, 123, -123);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(8);
        tests_run++;
        if ({bus.out_valid, bus.out_r, bus.out_i, bus.count, bus.primed} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b r=%0d i=%0d cnt=%0d pr=%b, want all 0",
                     bus.out_valid, bus.out_r, bus.out_i, bus.count, bus.primed);
        end
    endtask

    // D=8, samples 1..20 / -1..-20 back to back.
    task automatic test_fill();
        logic [DATA_W-1:0] er, ei;
        logic              ev;
        apply_reset(8);
        bus.en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, i, -i);
            tick();
            ev = (i >= 8);
            er = ev ? DATA_W'(i - 7) : '0;
            ei = ev ? DATA_W'(-(i - 7)) : '0;
            tests_run++;
            if ({bus.out_valid, bus.out_r, bus.out_i} !== {ev, er, ei}) begin
                tests_failed++;
                $display("FAIL fill_out edge %0d: got v=%b r=%0d i=%0d, want v=%b r=%0d i=%0d",
                         i, bus.out_valid, bus.out_r, bus.out_i, ev, er, ei);
            end
            tests_run++;
            if ({bus.count, bus.primed} !== {CW'((i < 8) ? i : 8), ev}) begin
                tests_failed++;
                $display("FAIL fill_count edge %0d: got cnt=%0d pr=%b, want cnt=%0d pr=%b",
                         i, bus.count, bus.primed, (i < 8) ? i : 8, ev);
            end
        end
    endtask

    // D=4, stall 3 cycles after edge 6, then resume.
    task automatic test_stall();
        apply_reset(4);
        bus.en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i, -i);
            tick();
        end
        bus.en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 99 + c, -99);
            tick();
            tests_run++;
            if ({bus.out_valid, bus.out_r, bus.count, bus.primed} !==
                {1'b1, DATA_W'(3), CW'(4), 1'b1}) begin
                tests_failed++;
                $display("FAIL stall_hold cycle %0d: got v=%b r=%0d cnt=%0d pr=%b, want v=1 r=3 cnt=4 pr=1",
                         c, bus.out_valid, bus.out_r, bus.count, bus.primed);
            end
        end
        bus.en = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            drive(1'b1, i, -i);
            tick();
            tests_run++;
            if ({bus.out_valid, bus.out_r, bus.out_i} !== {1'b1, DATA_W'(i - 3), DATA_W'(-(i - 3))}) begin
                tests_failed++;
                $display("FAIL stall_resume edge %0d: got v=%b r=%0d, want v=1 r=%0d",
                         i, bus.out_valid, bus.out_r, i - 3);
            end
        end
    endtask

    // D=4, valid pattern 1,0,1,1,0,0,0,0 with in_r = 10+edge.
    task automatic test_bubbles();
        logic [7:0] vpat = 8'b1011_0000;   // edge 1 is the MSB
        int         exp_cnt [8] = '{1, 1, 2, 3, 2, 2, 1, 0};
        logic       ev;
        apply_reset(4);
        bus.en = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            drive(vpat[8 - e], 10 + e, 0);
            tick();
            tests_run++;
            if ({bus.count, bus.primed} !== {CW'(exp_cnt[e - 1]), 1'b0}) begin
                tests_failed++;
                $display("FAIL bubble_count edge %0d: got cnt=%0d pr=%b, want cnt=%0d pr=0",
                         e, bus.count, bus.primed, exp_cnt[e - 1]);
            end
            if (e >= 4) begin
                ev = vpat[8 - (e - 3)];
                tests_run++;
                if ({bus.out_valid, bus.out_r} !== {ev, DATA_W'(10 + e - 3)}) begin
                    tests_failed++;
                    $display("FAIL bubble_out edge %0d: got v=%b r=%0d, want v=%b r=%0d",
                             e, bus.out_valid, bus.out_r, ev, 10 + e - 3);
                end
            end
        end
    endtask

    // Sample on the first enabled edge after a (re)load must emerge after edge want_edge.
    task automatic check_latency(input string name, input int want_edge, input int tag);
        for (int e = 1; e <= want_edge; e++) begin
            if (e == 1) drive(1'b1, tag, -tag);
            else        drive(1'b0, 0, 0);
            tick();
            if (e < want_edge) begin
                tests_run++;
                if (bus.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s early edge %0d: got out_valid=%b r=%0d, want out_valid=0",
                             name, e, bus.out_valid, bus.out_r);
                end
            end else begin
                tests_run++;
                if ({bus.out_valid, bus.out_r, bus.count} !== {1'b1, DATA_W'(tag), CW'(1)}) begin
                    tests_failed++;
                    $display("FAIL %s arrive edge %0d: got v=%b r=%0d cnt=%0d, want v=1 r=%0d cnt=1",
                             name, e, bus.out_valid, bus.out_r, bus.count, tag);
                end
            end
        end
    endtask

    task automatic test_depth_change();
        apply_reset(4);
        bus.en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, -i);
            tick();
        end
        tests_run++;
        if (bus.primed !== 1'b1) begin
            tests_failed++;
            $display("FAIL depth_primed: got primed=%b, want 1", bus.primed);
        end
        bus.depth_cfg = CW'(16);
        bus.flush     = 1'b1;
        drive(1'b1, 77, -77);
        tick();
        bus.flush = 1'b0;
        tests_run++;
        if ({bus.out_valid, bus.out_r, bus.out_i, bus.count, bus.primed} !== '0) begin
            tests_failed++;
            $display("FAIL depth_flush: got v=%b r=%0d i=%0d cnt=%0d pr=%b, want all 0",
                     bus.out_valid, bus.out_r, bus.out_i, bus.count, bus.primed);
        end
        // Reverting depth_cfg without flush must not shorten the new delay.
        bus.depth_cfg = CW'(4);
        check_latency("depth16", 16, 100);
    endtask

    task automatic test_clamp();
        apply_reset(0);
        bus.en = 1'b1;
        drive(1'b1, 5, -5);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_r, bus.count, bus.primed} !== {1'b1, DATA_W'(5), CW'(1), 1'b1}) begin
            tests_failed++;
            $display("FAIL clamp0_first: got v=%b r=%0d cnt=%0d pr=%b, want v=1 r=5 cnt=1 pr=1",
                     bus.out_valid, bus.out_r, bus.count, bus.primed);
        end
        drive(1'b0, 6, -6);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.count, bus.primed} !== {1'b0, CW'(0), 1'b0}) begin
            tests_failed++;
            $display("FAIL clamp0_bubble: got v=%b cnt=%0d pr=%b, want v=0 cnt=0 pr=0",
                     bus.out_valid, bus.count, bus.primed);
        end
        apply_reset(20);
        bus.en = 1'b1;
        check_latency("clamp20", 16, 9);
    endtask

    task automatic test_reset_midstream();
        apply_reset(4);
        bus.en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i, -i);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 55, -55);
        tick();
        rst = 1'b0;
        tests_run++;
        if ({bus.out_valid, bus.out_r, bus.out_i, bus.count, bus.primed} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_state: got v=%b r=%0d i=%0d cnt=%0d pr=%b, want all 0",
                     bus.out_valid, bus.out_r, bus.out_i, bus.count, bus.primed);
        end
        for (int e = 1; e <= 4; e++) begin
            drive(1'b0, 0, 0);
            tick();
            tests_run++;
            if ({bus.out_valid, bus.count} !== {1'b0, CW'(0)}) begin
                tests_failed++;
                $display("FAIL midreset_drop edge %0d: got v=%b r=%0d cnt=%0d, want v=0 cnt=0",
                         e, bus.out_valid, bus.out_r, bus.count);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.flush     = 1'b0;
        bus.depth_cfg = CW'(8);
        drive(1'b0, 0, 0);
        test_reset();
        test_fill();
        test_stall();
        test_bubbles();
        test_depth_change();
        test_clamp();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
